// File: rtl/mix_core_pkg.sv
// Shared types, default geometry and helper functions for the mix_core lane mixer.
package mix_core_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_LANES  = 8;
  localparam int unsigned DEF_ROUNDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Fold step shifts the neighbour lane by half a word.
  function automatic int unsigned mix_shift(input int unsigned width);
    return width / 2;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/mix_core_if.sv
// Seed-in / result-out handshake bundle for mix_core.
interface mix_core_if
  import mix_core_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LANES = DEF_LANES
);
  localparam int unsigned DW = WIDTH * LANES;

  logic          seed_valid;
  logic          seed_ready;
  logic [DW-1:0] seed_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;

  modport master (
    output seed_valid, seed_data, out_ready,
    input  seed_ready, out_valid, out_data, busy
  );

  modport slave (
    input  seed_valid, seed_data, out_ready,
    output seed_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/mix_round.sv
// One combinational mixing round: per-lane add, full carry chain across lanes, half-word fold.
module mix_round
  import mix_core_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned RW    = 1
) (
  input  logic [LANES*WIDTH-1:0] state,
  input  logic [RW-1:0]          r,
  output logic [LANES*WIDTH-1:0] state_nxt_c
);
  localparam int unsigned SH = mix_shift(WIDTH);

  logic [LANES-1:0][WIDTH-1:0] t;
  logic [LANES-1:0][WIDTH-1:0] u;

  // Chain wraps lane LANES-1 into lane 0, then ripples upward in one cycle.
  always_comb begin
    t           = '0;
    u           = '0;
    state_nxt_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      t[i] = state[i*WIDTH +: WIDTH] + WIDTH'(i) + WIDTH'(r);
    end
    u[0] = t[0] + t[LANES-1];
    for (int unsigned i = 1; i < LANES; i++) begin
      u[i] = t[i] + u[i-1];
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      state_nxt_c[i*WIDTH +: WIDTH] = u[i] ^ (u[(i+1) % LANES] << SH);
    end
  end

endmodule

// File: rtl/mix_core.sv
// Multi-round lane mixer: accepts a seed, runs ROUNDS rounds, holds the result until taken.
// Build option: MIX_CORE_ACCUM_EN xors each accepted seed into the previous state instead of replacing it.
module mix_core
  import mix_core_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned ROUNDS = DEF_ROUNDS
) (
  input logic       clk,
  input logic       rst_n,
  mix_core_if.slave bus
);
  localparam int unsigned DW = WIDTH * LANES;
  localparam int unsigned RW = cnt_width(ROUNDS);

  state_t        state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [DW-1:0] s_q, s_d, s_round;
  logic          seed_ready_q, seed_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          accept;

  assign accept = bus.seed_valid & seed_ready_q;

  mix_round #(.WIDTH(WIDTH), .LANES(LANES), .RW(RW)) u_round (
    .state       (s_q),
    .r           (r_q),
    .state_nxt_c (s_round)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      r_q          <= '0;
      s_q          <= '0;
      seed_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      s_q          <= s_d;
      seed_ready_q <= seed_ready_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (r_q == RW'(ROUNDS - 1)) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates plus next values of the registered handshake outputs.
  always_comb begin
    r_d          = r_q;
    s_d          = s_q;
    seed_ready_d = (state_d == IDLE);
    out_valid_d  = (state_d == DONE);
    busy_d       = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          r_d = '0;
`ifdef MIX_CORE_ACCUM_EN
          s_d = s_q ^ bus.seed_data;
`else
          s_d = bus.seed_data;
`endif
        end
      end
      RUN: begin
        s_d = s_round;
        r_d = r_q + RW'(1);
      end
      default: ;
    endcase
  end

  assign bus.seed_ready = seed_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = s_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mix_core.sv
// Self-checking bench for mix_core: three instances (8x2 R1, 8x2 R2, default 32x8 R4) against a behavioural model.
module tb_mix_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mix_core_if #(.WIDTH(8),  .LANES(2)) if_r1 ();
  mix_core_if #(.WIDTH(8),  .LANES(2)) if_r2 ();
  mix_core_if #(.WIDTH(32), .LANES(8)) if_df ();

  mix_core #(.WIDTH(8), .LANES(2), .ROUNDS(1)) dut_r1 (.clk(clk), .rst_n(rst_n), .bus(if_r1.slave));
  mix_core #(.WIDTH(8), .LANES(2), .ROUNDS(2)) dut_r2 (.clk(clk), .rst_n(rst_n), .bus(if_r2.slave));
  mix_core dut_df (.clk(clk), .rst_n(rst_n), .bus(if_df.slave));

  int checks = 0;
  int errors = 0;
  logic [255:0] prev [3];

  function automatic int w_of(input int which);
    return (which == 2) ? 32 : 8;
  endfunction
  function automatic int l_of(input int which);
    return (which == 2) ? 8 : 2;
  endfunction
  function automatic int r_of(input int which);
    return (which == 0) ? 1 : (which == 1) ? 2 : 4;
  endfunction

  // Behavioural model: word-level arithmetic straight from the round definition.
  function automatic logic [255:0] mix_model(input logic [255:0] st, input int w, input int l, input int rounds);
    longint unsigned mask, s[8], t[8], u[8];
    logic [255:0] res;
    mask = (64'd1 << w) - 64'd1;
    for (int i = 0; i < l; i++) s[i] = 64'(st >> (i * w)) & mask;
    for (int r = 0; r < rounds; r++) begin
      for (int i = 0; i < l; i++) t[i] = (s[i] + longint'(i) + longint'(r)) & mask;
      u[0] = (t[0] + t[l-1]) & mask;
      for (int i = 1; i < l; i++) u[i] = (t[i] + u[i-1]) & mask;
      for (int i = 0; i < l; i++) s[i] = (u[i] ^ (u[(i+1) % l] << (w / 2))) & mask;
    end
    res = '0;
    for (int i = 0; i < l; i++) res = res | (256'(s[i]) << (i * w));
    return res;
  endfunction

  function automatic logic [255:0] eff_seed(input int which, input logic [255:0] seed);
`ifdef MIX_CORE_ACCUM_EN
    return prev[which] ^ seed;
`else
    return seed;
`endif
  endfunction

  function automatic logic [255:0] rnd_seed(input int which);
    logic [255:0] v = '0;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return (which == 2) ? v : {240'd0, v[15:0]};
  endfunction

  task automatic drv_seed(input int which, input logic v, input logic [255:0] d);
    case (which)
      0: begin if_r1.seed_valid = v; if_r1.seed_data = d[15:0]; end
      1: begin if_r2.seed_valid = v; if_r2.seed_data = d[15:0]; end
      default: begin if_df.seed_valid = v; if_df.seed_data = d; end
    endcase
  endtask

  task automatic drv_ready(input int which, input logic v);
    case (which)
      0: if_r1.out_ready = v;
      1: if_r2.out_ready = v;
      default: if_df.out_ready = v;
    endcase
  endtask

  function automatic logic rd_valid(input int which);
    return (which == 0) ? if_r1.out_valid : (which == 1) ? if_r2.out_valid : if_df.out_valid;
  endfunction
  function automatic logic rd_sready(input int which);
    return (which == 0) ? if_r1.seed_ready : (which == 1) ? if_r2.seed_ready : if_df.seed_ready;
  endfunction
  function automatic logic rd_busy(input int which);
    return (which == 0) ? if_r1.busy : (which == 1) ? if_r2.busy : if_df.busy;
  endfunction
  function automatic logic [255:0] rd_data(input int which);
    return (which == 0) ? 256'(if_r1.out_data) : (which == 1) ? 256'(if_r2.out_data) : if_df.out_data;
  endfunction

  // Runs one job from IDLE; lat = edges from acceptance to out_valid, -1 on timeout.
  task automatic job(input int which, input logic [255:0] seed, input bit noise,
                     output logic [255:0] data, output int lat);
    int guard = 0;
    drv_ready(which, 1'b0);
    while (!rd_sready(which) && guard < 10) begin @(negedge clk); guard++; end
    drv_seed(which, 1'b1, seed);
    @(negedge clk);
    drv_seed(which, noise, noise ? rnd_seed(which) : '0);
    lat = 0;
    while (!rd_valid(which) && lat < 40) begin @(negedge clk); lat++; end
    if (!rd_valid(which)) lat = -1;
    data = rd_data(which);
    drv_ready(which, 1'b1);
    @(negedge clk);
    drv_ready(which, 1'b0);
    drv_seed(which, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) prev[k] = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd_valid(k) !== 1'b0 || rd_busy(k) !== 1'b0 || rd_sready(k) !== 1'b0 || rd_data(k) !== '0) begin
        errors++;
        $display("FAIL reset_state inst=%0d got v=%b b=%b r=%b d=%h need all zero", k,
                 rd_valid(k), rd_busy(k), rd_sready(k), rd_data(k));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (if_r1.seed_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge got %b need 0", if_r1.seed_ready);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd_sready(k) !== 1'b1) begin
        errors++; $display("FAIL ready_after_reset inst=%0d got %b need 1", k, rd_sready(k));
      end
    end
    for (int k = 0; k < 3; k++) prev[k] = '0;
  endtask

  task automatic test_directed();
    logic [255:0] d;
    int lat;
    do_reset();
    job(0, 256'h0000, 1'b0, d, lat);
    checks++;
    if (d !== 256'h1221 || lat !== 1) begin
      errors++; $display("FAIL r1_zero got %h lat %0d need 1221 lat 1", d, lat);
    end
    do_reset();
    job(1, 256'h0000, 1'b0, d, lat);
    checks++;
    if (d !== 256'h2A96 || lat !== 2) begin
      errors++; $display("FAIL r2_zero got %h lat %0d need 2a96 lat 2", d, lat);
    end
    do_reset();
    job(0, 256'hFFFF, 1'b0, d, lat);
    checks++;
    if (d !== 256'h0F0F) begin
      errors++; $display("FAIL r1_wrap got %h need 0f0f", d);
    end
    prev[0] = 256'h0F0F;
  endtask

  task automatic test_back_to_back();
    logic [255:0] d, exp2;
    int lat;
`ifdef MIX_CORE_ACCUM_EN
    exp2 = 256'h0744;
`else
    exp2 = 256'h1221;
`endif
    do_reset();
    job(0, 256'h0, 1'b0, d, lat);
    checks++;
    if (d !== 256'h1221) begin
      errors++; $display("FAIL b2b_first got %h need 1221", d);
    end
    job(0, 256'h0, 1'b0, d, lat);
    checks++;
    if (d !== exp2) begin
      errors++; $display("FAIL b2b_second got %h need %h", d, exp2);
    end
    prev[0] = exp2;
  endtask

  task automatic test_hold();
    logic [255:0] sa, sb, exp1, exp2;
    int guard;
    sa = rnd_seed(0);
    sb = rnd_seed(0);
    exp1 = mix_model(eff_seed(0, sa), 8, 2, 1);
    prev[0] = exp1;
    exp2 = mix_model(eff_seed(0, sb), 8, 2, 1);
    if_r1.out_ready = 1'b0;
    drv_seed(0, 1'b1, sa);
    @(negedge clk);
    drv_seed(0, 1'b1, sb);
    guard = 0;
    while (!if_r1.out_valid && guard < 20) begin @(negedge clk); guard++; end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (if_r1.out_valid !== 1'b1 || if_r1.seed_ready !== 1'b0 || 256'(if_r1.out_data) !== exp1) begin
        errors++;
        $display("FAIL hold cyc=%0d got v=%b rdy=%b d=%h need v=1 rdy=0 d=%h", c,
                 if_r1.out_valid, if_r1.seed_ready, if_r1.out_data, exp1[15:0]);
      end
      @(negedge clk);
    end
    if_r1.out_ready = 1'b1;
    @(negedge clk);
    if_r1.out_ready = 1'b0;
    checks++;
    if (if_r1.seed_ready !== 1'b1 || if_r1.out_valid !== 1'b0 || if_r1.busy !== 1'b0) begin
      errors++; $display("FAIL hold_release got rdy=%b v=%b busy=%b need 1 0 0",
                         if_r1.seed_ready, if_r1.out_valid, if_r1.busy);
    end
    @(negedge clk);
    drv_seed(0, 1'b0, '0);
    checks++;
    if (if_r1.busy !== 1'b1 || if_r1.seed_ready !== 1'b0) begin
      errors++; $display("FAIL hold_accept got busy=%b rdy=%b need 1 0", if_r1.busy, if_r1.seed_ready);
    end
    @(negedge clk);
    checks++;
    if (if_r1.out_valid !== 1'b1 || 256'(if_r1.out_data) !== exp2) begin
      errors++; $display("FAIL hold_second got v=%b d=%h need v=1 d=%h", if_r1.out_valid, if_r1.out_data, exp2[15:0]);
    end
    if_r1.out_ready = 1'b1;
    @(negedge clk);
    if_r1.out_ready = 1'b0;
    prev[0] = exp2;
  endtask

  task automatic test_random();
    logic [255:0] seed, exp, d;
    int lat, which;
    for (int k = 0; k < 15; k++) begin
      which = k % 3;
      seed = rnd_seed(which);
      exp = mix_model(eff_seed(which, seed), w_of(which), l_of(which), r_of(which));
      prev[which] = exp;
      job(which, seed, k[0], d, lat);
      checks++;
      if (d !== exp || lat !== r_of(which)) begin
        errors++; $display("FAIL random k=%0d inst=%0d got %h lat %0d need %h lat %0d",
                           k, which, d, lat, exp, r_of(which));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int seen = 0;
    do_reset();
    drv_seed(2, 1'b1, rnd_seed(2));
    @(negedge clk);
    drv_seed(2, 1'b0, '0);
    @(posedge clk);
    #2;
    checks++;
    if (if_df.busy !== 1'b1 || if_df.out_valid !== 1'b0) begin
      errors++; $display("FAIL midrun_busy got busy=%b v=%b need 1 0", if_df.busy, if_df.out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (if_df.out_valid !== 1'b0 || if_df.out_data !== '0 || if_df.busy !== 1'b0) begin
      errors++; $display("FAIL midrun_reset got v=%b busy=%b d=%h need 0 0 0",
                         if_df.out_valid, if_df.busy, if_df.out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (if_df.out_valid !== 1'b0 || if_df.busy !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midrun_no_result got %0d active cycles need 0", seen);
    end
    for (int k = 0; k < 3; k++) prev[k] = '0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      drv_seed(k, 1'b0, '0);
      drv_ready(k, 1'b0);
      prev[k] = '0;
    end
    test_reset();
    test_directed();
    test_back_to_back();
    test_hold();
    test_random();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
